// File: rtl/match_count_fsm_if.sv
// Sample/handshake bundle for match_count_fsm.
// The mask signal exists only when MATCH_COUNT_MASK_EN is defined.
interface match_count_fsm_if #(
  parameter int DATA_W = 4
);
  logic              valid;
  logic [DATA_W-1:0] num;
  logic [DATA_W-1:0] seq;
`ifdef MATCH_COUNT_MASK_EN
  logic [DATA_W-1:0] mask;
`endif
  logic              ready;

  modport master (
`ifdef MATCH_COUNT_MASK_EN
    output mask,
`endif
    output valid, num, seq,
    input  ready
  );

  modport slave (
`ifdef MATCH_COUNT_MASK_EN
    input  mask,
`endif
    input  valid, num, seq,
    output ready
  );
endinterface

// File: rtl/match_count_fsm.sv
// Counts seq==num matches over a valid burst, then replays one hit pulse per match.
// MATCH_COUNT_MASK_EN adds a don't-care mask to the compare.
module match_count_fsm #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  match_count_fsm_if.slave bus,
  output logic             hit,
  output logic             done,
  output logic             sat,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HIT   = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             done_q, done_d;
  logic [DATA_W-1:0] diff;
  logic             match;

  always_comb begin
`ifdef MATCH_COUNT_MASK_EN
    diff = (bus.seq ^ bus.num) & ~bus.mask;
`else
    diff = bus.seq ^ bus.num;
`endif
    match = bus.valid && (diff == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          state_d = COUNT;
          cnt_d   = match ? CNT_ONE : '0;
          sat_d   = 1'b0;
        end else begin
          cnt_d = '0;
        end
      end
      COUNT: begin
        if (bus.valid) begin
          if (match) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_ONE;
          end
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = HIT;
        end
      end
      HIT: begin
        // Leaving on cnt<=1 also recovers if HIT were ever reached with cnt=0.
        if (cnt_q <= CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign hit       = (state_q == HIT);
  assign bus.ready = (state_q != HIT);
  assign done      = done_q;
  assign sat       = sat_q;
  assign state     = state_q;
  assign cnt       = cnt_q;

endmodule

// File: doc/match_count_fsm.md
MATCH_COUNT_FSM -- requirements
Module: match_count_fsm

Interface
REQ-001 Parameter DATA_W, default 4: width of num, seq and mask.
REQ-002 Parameter CNT_W, default 4: width of the match counter; maximum count is 2^CNT_W-1.
REQ-003 Port clock  in  1: single clock; all state changes on the rising edge.
REQ-004 Port reset  in  1: reset, synchronous and active-high.
REQ-005 Port valid  in  1: the current seq sample is part of the burst.
REQ-006 Port num  in  DATA_W: reference value, compared live every cycle.
REQ-007 Port seq  in  DATA_W: sample compared against num.
REQ-008 Port mask  in  DATA_W: don't-care bits; 1 means ignore that bit; present only when the Configuration macro is defined.
REQ-009 Port ready  out  1: high in IDLE and COUNT; low in HIT.
REQ-010 Port hit  out  1: high for exactly one cycle per counted match during replay.
REQ-011 Port done  out  1: one-cycle pulse when the block returns to IDLE at the end of a burst.
REQ-012 Port sat  out  1: sticky flag; the counter saturated during the current burst.
REQ-013 Port state  out  2: debug view of the state register; IDLE=00, COUNT=01, HIT=10.
REQ-014 Port cnt  out  CNT_W: debug view of the counter register.

Function
REQ-015 A sample matches when valid=1 and seq equals num, compared over all DATA_W bits (masked form in REQ-030).
REQ-016 IDLE with valid=1: enter COUNT; cnt becomes 1 on a match, 0 otherwise; sat cleared.
REQ-017 IDLE with valid=0: stay in IDLE; cnt holds 0.
REQ-018 COUNT with valid=1: cnt increments by 1 on each match and holds on a non-match.
REQ-019 Saturation: when cnt=2^CNT_W-1, a further match leaves cnt unchanged and sets sat=1; the counter never wraps.
REQ-020 COUNT with valid=0 and cnt=0: enter IDLE and pulse done on the following cycle; hit stays 0.
REQ-021 COUNT with valid=0 and cnt>0: enter HIT; cnt holds its value.
REQ-022 hit = (state==HIT), decoded from the state register with no combinational path from any input.
REQ-023 HIT, each edge: cnt decrements by 1; at the edge where cnt=1, enter IDLE with cnt=0.
REQ-024 Replay timing: hit is high for exactly N consecutive cycles, N being the final count, starting the cycle after the first valid=0 sample.
REQ-025 done is registered; it is high during the first IDLE cycle after leaving COUNT (zero matches) or HIT.
REQ-026 valid and seq are ignored in HIT; a burst offered while ready=0 is dropped and upstream must hold off.
REQ-027 A new burst is accepted in the same cycle done is high, i.e. valid=1 in that IDLE cycle enters COUNT.
REQ-028 sat holds through HIT and clears on the next IDLE->COUNT transition.

Reset
REQ-029 reset=1 at a rising edge forces the next-cycle values state=IDLE, cnt=0, sat=0, done=0 and hit=0 from any state, mid-burst or mid-replay included, with priority over all other inputs; ready=1 follows from IDLE.

Configuration
REQ-030 Macro MATCH_COUNT_MASK_EN defined: mask port exists; a match is ((seq^num)&~mask)==0.
REQ-031 Macro MATCH_COUNT_MASK_EN undefined: mask port absent; exact compare; all other behaviour is identical.

Verification (DATA_W=4, CNT_W=4)
REQ-032 num=5, 10 valid cycles with seq=10 -> hit never high, cnt=0, done one pulse, ready always 1.
REQ-033 num=5, 10 valid cycles with seq=5 -> cnt=10; hit high exactly 10 consecutive cycles starting the cycle after valid falls; done high the cycle after the last hit.
REQ-034 num=5, 20 matching valid cycles -> cnt=15, sat=1, exactly 15 hit cycles, then sat clears on the next burst.
REQ-035 3 matches, then valid=1 with seq=num for 2 cycles inside HIT -> ready=0, those samples ignored, exactly 3 hit cycles.
REQ-036 8 matches, reset=1 for one edge after the 4th hit cycle -> next cycle state=IDLE, cnt=0, hit=0, no done pulse.
REQ-037 With MATCH_COUNT_MASK_EN defined, mask=0011, num=5, seq=6 for 4 valid cycles -> 4 hit cycles; mask=0000 with the same stimulus -> 0 hit cycles.
